// File: rtl/isp_pkg.sv
// Shared ISP definitions: line-delay FSM encoding and default geometry.
package isp_pkg;

   localparam int unsigned DWIDTH_DEF = 16;
   localparam int unsigned AWIDTH_DEF = 12;
   localparam int unsigned LINE_W_DEF = 1920;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_FILL   = 2'd2,
      ST_STREAM = 2'd3
   } state_e;

endpackage

// File: rtl/line_delay_ctrl.sv
// One-line delay controller pairing each pixel with the same column of the previous line
// through an external show-ahead FIFO. Macro LINE_DELAY_CNT_EN enables the line counter.
module line_delay_ctrl
   import isp_pkg::*;
#(
   parameter int unsigned DWIDTH = DWIDTH_DEF,
   parameter int unsigned AWIDTH = AWIDTH_DEF,
   parameter int unsigned LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sof,
   input  logic              in_vld,
   input  logic [DWIDTH-1:0] in_pix,
   output logic              fifo_we,
   output logic              fifo_re,
   output logic [DWIDTH-1:0] fifo_di,
   input  logic              fifo_full,
   input  logic              fifo_empty,
   input  logic [DWIDTH-1:0] fifo_dout,
   output logic              out_vld,
   output logic [DWIDTH-1:0] out_cur,
   output logic [DWIDTH-1:0] out_prev,
   output logic              ovf_err,
   output logic              unf_err,
   output logic              drop_err,
   output logic [11:0]       line_cnt
);

   localparam logic [AWIDTH-1:0] LAST_PIX = AWIDTH'(LINE_W - 1);

   state_e              state_q, state_d;
   logic [AWIDTH-1:0]   pix_q, pix_d;
   logic                out_vld_q;
   logic [DWIDTH-1:0]   out_cur_q, out_prev_q;
   logic                ovf_q, unf_q, drop_q;
   logic                ovf_d, unf_d, drop_d;
   logic                stream_hit;

   assign stream_hit = (state_q == ST_STREAM) && in_vld;
   assign fifo_di    = in_pix;

   always_comb begin
      fifo_we = 1'b0;
      fifo_re = 1'b0;
      unique case (state_q)
         ST_FLUSH:  fifo_re = ~fifo_empty;
         ST_FILL:   fifo_we = in_vld;
         ST_STREAM: begin
            fifo_we = in_vld;
            fifo_re = in_vld;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      unique case (state_q)
         ST_IDLE: ;
         ST_FLUSH: begin
            if (fifo_empty) begin
               state_d = ST_FILL;
               pix_d   = '0;
            end
         end
         ST_FILL: begin
            if (in_vld) begin
               if (pix_q == LAST_PIX) begin
                  state_d = ST_STREAM;
                  pix_d   = '0;
               end else begin
                  pix_d = pix_q + 1'b1;
               end
            end
         end
         ST_STREAM: begin
            if (in_vld) pix_d = (pix_q == LAST_PIX) ? '0 : pix_q + 1'b1;
         end
         default: ;
      endcase
      // A new frame always restarts with a flush, whatever the current state.
      if (sof) begin
         state_d = ST_FLUSH;
         pix_d   = '0;
      end
   end

   // Error flags: a set in the same cycle as sof wins over the clear.
   assign ovf_d  = (fifo_we & fifo_full) | (ovf_q & ~sof);
   assign unf_d  = (fifo_re & fifo_empty & (state_q == ST_STREAM)) | (unf_q & ~sof);
   assign drop_d = (in_vld & ((state_q == ST_IDLE) | (state_q == ST_FLUSH))) | (drop_q & ~sof);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         pix_q      <= '0;
         out_vld_q  <= 1'b0;
         out_cur_q  <= '0;
         out_prev_q <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pix_q     <= pix_d;
         out_vld_q <= stream_hit;
         if (stream_hit) begin
            out_cur_q  <= in_pix;
            out_prev_q <= fifo_dout;
         end
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
         drop_q <= drop_d;
      end
   end

   assign out_vld  = out_vld_q;
   assign out_cur  = out_cur_q;
   assign out_prev = out_prev_q;
   assign ovf_err  = ovf_q;
   assign unf_err  = unf_q;
   assign drop_err = drop_q;

`ifdef LINE_DELAY_CNT_EN
   logic        line_wrap;
   logic [11:0] line_cnt_q;

   assign line_wrap = stream_hit && (pix_q == LAST_PIX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         line_cnt_q <= '0;
      end else if (sof) begin
         line_cnt_q <= '0;
      end else if (line_wrap) begin
         line_cnt_q <= line_cnt_q + 12'd1;
      end
   end

   assign line_cnt = line_cnt_q;
`else
   assign line_cnt = '0;
`endif

endmodule

// File: tb/tb_line_delay_ctrl.sv
// Bench for line_delay_ctrl: behavioural FIFO plus a frame-level reference model
// (pixels accepted since the last flush, paired with the one LINE_W pixels earlier).
module tb_line_delay_ctrl;

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 3;
   localparam int unsigned LW    = 4;
   localparam int unsigned DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          sof;
   logic          in_vld;
   logic [DW-1:0] in_pix;
   logic          fifo_we, fifo_re;
   logic [DW-1:0] fifo_di;
   logic          fifo_full, fifo_empty;
   logic [DW-1:0] fifo_dout;
   logic          out_vld;
   logic [DW-1:0] out_cur, out_prev;
   logic          ovf_err, unf_err, drop_err;
   logic [11:0]   line_cnt;

   logic [DW-1:0] fq[$];
   bit            force_full, force_empty;
   int            checks = 0;
   int            errors = 0;

   // Reference model
   bit            m_active, m_flushing, m_ovf, m_unf, m_drop;
   int            m_n, m_lines;
   logic [DW-1:0] m_hist[$];
   bit            e_vld;
   logic [DW-1:0] e_cur, e_prev;
   bit            last_re;

   always #5 clk = ~clk;

   line_delay_ctrl #(
      .DWIDTH (DW),
      .AWIDTH (AW),
      .LINE_W (LW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sof        (sof),
      .in_vld     (in_vld),
      .in_pix     (in_pix),
      .fifo_we    (fifo_we),
      .fifo_re    (fifo_re),
      .fifo_di    (fifo_di),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .out_vld    (out_vld),
      .out_cur    (out_cur),
      .out_prev   (out_prev),
      .ovf_err    (ovf_err),
      .unf_err    (unf_err),
      .drop_err   (drop_err),
      .line_cnt   (line_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lines();
`ifdef LINE_DELAY_CNT_EN
      return m_lines;
`else
      return 0;
`endif
   endfunction

   task automatic upd_flags();
      fifo_empty = (fq.size() == 0) || force_empty;
      fifo_full  = (fq.size() >= DEPTH) || force_full;
      fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
   endtask

   task automatic model_reset();
      m_active = 0; m_flushing = 0; m_ovf = 0; m_unf = 0; m_drop = 0;
      m_n = 0; m_lines = 0; m_hist.delete();
      e_vld = 0; e_cur = '0; e_prev = '0;
   endtask

   task automatic check_outputs();
      chk("out_vld", out_vld, e_vld);
      if (e_vld) begin
         chk("out_cur", out_cur, e_cur);
         chk("out_prev", out_prev, e_prev);
      end
      chk("ovf_err", ovf_err, m_ovf);
      chk("unf_err", unf_err, m_unf);
      chk("drop_err", drop_err, m_drop);
      chk("line_cnt", line_cnt, exp_lines());
   endtask

   // One clock: inputs are already driven; check strobes, advance model and FIFO, check outputs.
   task automatic cycle();
      bit x_we, x_re, s_we, s_re;
      logic [DW-1:0] s_di;
      bit set_ovf, set_unf, set_drop;
      #3;
      x_we = 0; x_re = 0;
      if (m_flushing) begin
         x_re = !fifo_empty;
      end else if (m_active) begin
         x_we = in_vld;
         x_re = in_vld && (m_n >= LW);
      end
      chk("fifo_we", fifo_we, x_we);
      chk("fifo_re", fifo_re, x_re);
      if (x_we) chk("fifo_di", fifo_di, in_pix);
      s_we = fifo_we; s_re = fifo_re; s_di = fifo_di;
      last_re = s_re;

      e_vld = m_active && in_vld && (m_n >= LW);
      if (e_vld) begin
         e_cur  = in_pix;
         e_prev = m_hist[0];
      end
      set_ovf  = x_we && fifo_full;
      set_unf  = m_active && x_re && fifo_empty;
      set_drop = in_vld && !m_active;
      m_ovf  = set_ovf  || (m_ovf  && !sof);
      m_unf  = set_unf  || (m_unf  && !sof);
      m_drop = set_drop || (m_drop && !sof);
      if (m_active && in_vld) begin
         m_hist.push_back(in_pix);
         if (m_hist.size() > LW) void'(m_hist.pop_front());
         m_n++;
         if ((m_n % LW == 0) && (m_n > LW)) m_lines = (m_lines + 1) % 4096;
      end
      if (sof) begin
         m_flushing = 1; m_active = 0; m_n = 0; m_lines = 0;
         m_hist.delete();
      end else if (m_flushing && fifo_empty) begin
         m_flushing = 0; m_active = 1;
      end

      @(posedge clk);
      #1;
      if (s_re && fq.size() != 0) void'(fq.pop_front());
      if (s_we) fq.push_back(s_di);
      upd_flags();
      check_outputs();
   endtask

   task automatic drive(input bit s, input bit v, input logic [DW-1:0] p);
      sof = s; in_vld = v; in_pix = p;
      cycle();
   endtask

   initial begin
      int rd_cnt;
      rst = 1'b0; sof = 0; in_vld = 0; in_pix = '0;
      force_full = 0; force_empty = 0;
      upd_flags();
      model_reset();
      #1;
      chk("rst_out_vld", out_vld, 0);
      chk("rst_out_cur", out_cur, 0);
      chk("rst_out_prev", out_prev, 0);
      chk("rst_errs", {ovf_err, unf_err, drop_err}, 0);
      chk("rst_line_cnt", line_cnt, 0);
      chk("rst_strobes", {fifo_we, fifo_re}, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;

      // Frame start on an empty FIFO, fill one line, then stream the next one.
      drive(1, 0, '0);
      drive(0, 0, '0);
      for (int i = 1; i <= 4; i++) drive(0, 1, DW'(i));
      chk("fill_words", fq.size(), 4);
      for (int i = 5; i <= 8; i++) begin
         drive(0, 1, DW'(i));
         chk("pair_cur", out_cur, DW'(i));
         chk("pair_prev", out_prev, DW'(i - 4));
      end
      chk("line_cnt_8", line_cnt, exp_lines());

      // Gapped input: one valid, two idle.
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, DW'($urandom));
         drive(0, 0, '0);
         drive(0, 0, '0);
      end

      // Mid-line sof with a full line held: flush drains it before refilling.
      drive(1, 0, '0);
      rd_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         drive(0, 0, '0);
         rd_cnt += int'(last_re);
      end
      chk("flush_reads", rd_cnt, 4);
      chk("flush_line_cnt", line_cnt, 0);

      // Overflow while filling; stays set until the next sof.
      force_full = 1; upd_flags();
      drive(0, 1, DW'($urandom));
      force_full = 0; upd_flags();
      chk("ovf_set", ovf_err, 1);
      for (int i = 0; i < 5; i++) drive(0, 1, DW'($urandom));
      // Underflow: head reported missing while streaming.
      force_empty = 1; upd_flags();
      drive(0, 1, DW'($urandom));
      force_empty = 0; upd_flags();
      chk("unf_set", unf_err, 1);
      drive(0, 1, DW'($urandom));
      drive(1, 0, '0);
      chk("sof_clears_ovf", ovf_err, 0);
      drive(0, 1, DW'($urandom));
      chk("drop_set", drop_err, 1);

      // Random traffic with occasional frame restarts.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) drive(1, 0, '0);
         else drive(0, ($urandom_range(0, 2) != 0), DW'($urandom));
      end

      // Asynchronous reset in the middle of a streaming line.
      drive(1, 0, '0);
      for (int i = 0; i < 8; i++) drive(0, 0, '0);
      for (int i = 0; i < 6; i++) drive(0, 1, DW'($urandom));
      sof = 0; in_vld = 1; in_pix = 16'hbeef;
      #3;
      rst = 1'b0;
      #1;
      chk("arst_out_vld", out_vld, 0);
      chk("arst_out_cur", out_cur, 0);
      chk("arst_out_prev", out_prev, 0);
      chk("arst_errs", {ovf_err, unf_err, drop_err}, 0);
      chk("arst_line_cnt", line_cnt, 0);
      chk("arst_strobes", {fifo_we, fifo_re}, 0);
      @(posedge clk); #1;
      model_reset();
      in_vld = 0;
      rst = 1'b1;

      // Recovery: stale FIFO words are flushed by the next frame start.
      drive(1, 0, '0);
      for (int i = 0; i < 8; i++) drive(0, 0, '0);
      for (int i = 0; i < 12; i++) drive(0, 1, DW'($urandom));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/line_delay_ctrl.md
LINE_DELAY_CTRL -- requirements
Module: line_delay_ctrl

Interface
REQ-001 Parameter DWIDTH, 16, pixel width.
REQ-002 Parameter AWIDTH, 12, FIFO address width; LINE_W SHALL satisfy 2 <= LINE_W <= 2**AWIDTH-1.
REQ-003 Parameter LINE_W, 1920, pixels per line.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 sof  in  1  start-of-frame pulse, one cycle, never coincident with in_vld.
REQ-007 in_vld / in_pix  in  1 / DWIDTH  incoming pixel stream.
REQ-008 fifo_we / fifo_re  out  1 / 1  FIFO write and read strobes, combinational from state and in_vld.
REQ-009 fifo_di  out  DWIDTH  equals in_pix.
REQ-010 fifo_full / fifo_empty  in  1 / 1  FIFO status flags.
REQ-011 fifo_dout  in  DWIDTH  show-ahead FIFO head word.
REQ-012 out_vld  out  1  registered; pixel pair valid.
REQ-013 out_cur / out_prev  out  DWIDTH / DWIDTH  registered current-line pixel and same-column previous-line pixel.
REQ-014 ovf_err / unf_err / drop_err  out  1 each  sticky error flags.
REQ-015 line_cnt  out  12  completed-line count.

Function
REQ-016 States SHALL be IDLE, FLUSH, FILL, STREAM; pixel counter pix_cnt is AWIDTH bits wide.
REQ-017 IDLE: strobes 0; sof -> FLUSH.
REQ-018 FLUSH: fifo_re = ~fifo_empty each cycle; fifo_empty=1 -> FILL with pix_cnt=0.
REQ-019 FILL: in_vld -> fifo_we=1, pix_cnt+1; in_vld at pix_cnt==LINE_W-1 -> STREAM, pix_cnt=0; out_vld stays 0.
REQ-020 STREAM: in_vld -> fifo_we=1 and fifo_re=1 in the same cycle; FIFO occupancy stays LINE_W.
REQ-021 STREAM: next cycle out_vld=1, out_cur=in_pix, out_prev=fifo_dout sampled at the strobe cycle; latency exactly 1 cycle.
REQ-022 STREAM: pix_cnt wraps LINE_W-1 -> 0 on in_vld; each wrap increments line_cnt (mod 4096).
REQ-023 sof in FILL or STREAM -> FLUSH; out_vld=0 from next cycle.
REQ-024 in_vld in IDLE or FLUSH: pixel dropped, drop_err set, no strobe.
REQ-025 fifo_we while fifo_full sets ovf_err; fifo_re while fifo_empty in STREAM sets unf_err; strobes still issued.
REQ-026 sof clears ovf_err, unf_err, drop_err and line_cnt; set takes priority over clear in the same cycle.

Reset
REQ-027 rst low SHALL asynchronously force IDLE, pix_cnt=0, line_cnt=0, out_vld=0, out_cur=0, out_prev=0, all error flags 0.
REQ-028 Strobes SHALL be 0 throughout reset.
REQ-029 Release SHALL be synchronous to clk.
REQ-030 Mid-frame reset SHALL leave FIFO contents undefined; the next sof flush recovers.

Configuration
REQ-031 Macro LINE_DELAY_CNT_EN defined: line_cnt behaves per REQ-022/026.
REQ-032 LINE_DELAY_CNT_EN undefined: line_cnt tied to 0, counter logic absent; all other behaviour unchanged.

Structure
REQ-033 State encoding (2-bit enum) and default LINE_W, DWIDTH, AWIDTH constants SHALL live in shared package isp_pkg.
REQ-034 No sub-module; the FIFO is instantiated beside this block by the parent and connected through the fifo_* ports.

Verification (LINE_W=4, DWIDTH=16, AWIDTH=3)
REQ-035 Reset, sof, 4 pixels 1..4 -> 4 writes, state STREAM, out_vld never 1.
REQ-036 Continue pixels 5..8 -> out pairs (cur,prev) = (5,1),(6,2),(7,3),(8,4), each 1 cycle after input; line_cnt=1.
REQ-037 Gapped in_vld (1 on, 2 off) in STREAM -> out_vld only after valid cycles; pairing preserved.
REQ-038 sof after 2 STREAM pixels with 4 words held -> FLUSH reads 4 words, FILL entered once fifo_empty=1, line_cnt=0.
REQ-039 Force fifo_full=1 in FILL -> ovf_err=1 until next sof; in_vld during FLUSH -> drop_err=1.
REQ-040 rst low mid-STREAM -> IDLE and all outputs 0 same cycle, without waiting for a clk edge.
